lcd_hd44780_ctrl: RTL and testbench
===================================

# lcd_hd44780_ctrl

Downstream consumer of the LSU's LCD output register: takes the 32-bit LCD command word that software stores to the output buffer and drives an HD44780-compatible character LCD. It runs the controller's write-cycle timing (setup, enable pulse, hold, execution wait) and the power-up delay in hardware. It reports `busy_o` so that software can poll the controller through an input-buffer bit.

## Interface
- `SETUP_CYC`, default 4: cycles RS/DATA are stable before EN rises (≥1).
- `EN_HIGH_CYC`, default 25: EN high width in cycles (≥1).
- `HOLD_CYC`, default 2: cycles RS/DATA are held after EN falls (≥1).
- `CMD_WAIT_CYC`, default 2000: execution wait for ordinary commands and data (≥1).
- `CLR_WAIT_CYC`, default 82000: execution wait for clear/home commands (≥1).
- `PWR_WAIT_CYC`, default 2000000: power-up delay after reset (≥1).
- Counter width is `$clog2` of the largest of these parameters plus 1.

Ports:
- `clk_i`, in, 1: single clock, all state on rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `lcd_word_i`, in, 32: LCD command word, already registered upstream.
  - [7:0] DATA
  - [8] RS
  - [9] ON
  - [10] REQ toggle
  - [31:11] ignored
- `lcd_data_o`, out, 8: LCD DB[7:0].
- `lcd_rs_o`, out, 1: LCD RS.
- `lcd_rw_o`, out, 1: LCD R/W, constant 0 (write-only).
- `lcd_en_o`, out, 1: LCD E.
- `lcd_on_o`, out, 1: LCD power/backlight.
- `busy_o`, out, 1: high while not in IDLE.

## Operation
- Registers:
  - `state`
  - `cnt`
  - `req_seen` (last accepted REQ value)
  - `data_q`, `rs_q` (shadow copies of the accepted command)
  - `on_q`
- All outputs are registered.
- A request is pending when `lcd_word_i[10] != req_seen`. It is evaluated only in IDLE.
- Accept (IDLE with a request pending):
  - latch DATA into `data_q` and RS into `rs_q`
  - set `req_seen` to `lcd_word_i[10]`
  - go to SETUP
- Changes to `lcd_word_i[8:0]` after acceptance do not affect the transaction in flight.
- Long wait: `rs_q==0` and `data_q` is 0x01, 0x02 or 0x03 selects `CLR_WAIT_CYC`. Every other command and all data writes use `CMD_WAIT_CYC`.
- FSM states:
  - PWRUP: after `PWR_WAIT_CYC` cycles → IDLE.
  - IDLE: request pending → SETUP.
  - SETUP: `SETUP_CYC` cycles → PULSE.
  - PULSE: `EN_HIGH_CYC` cycles, `lcd_en_o`=1 → HOLD.
  - HOLD: `HOLD_CYC` cycles → WAIT.
  - WAIT: selected wait count → IDLE.
- `cnt` loads N-1 on state entry and decrements to 0. The state advances on the cycle after `cnt==0`, so each state lasts exactly N cycles.
- `lcd_data_o` and `lcd_rs_o` drive `data_q` and `rs_q` in SETUP, PULSE and HOLD. They keep the last values in WAIT and IDLE; only the EN edge matters to the LCD.
- `on_q` loads `lcd_word_i[9]` every cycle in every state except PWRUP, where it stays 0. `lcd_on_o = on_q`.
- Two REQ toggles while busy cancel each other: no second transaction. Software must wait for `busy_o`=0 before toggling.
- Reset values:
  - `lcd_data_o`=0, `lcd_rs_o`=0, `lcd_rw_o`=0, `lcd_en_o`=0, `lcd_on_o`=0
  - `busy_o`=1
  - `state`=PWRUP, `req_seen`=0
- Reset mid-transaction: EN drops immediately (asynchronously), the transaction is abandoned and PWRUP restarts. If REQ is still 1 after reset, a fresh request is taken at the first IDLE.

## Timing
- Cycle 0: IDLE, request pending, accept edge.
- Cycle 1: SETUP; `busy_o`=1; RS/DATA valid.
- EN high on cycles `SETUP_CYC+1` .. `SETUP_CYC+EN_HIGH_CYC`.
- HOLD, then WAIT.
- `busy_o`=1 for exactly `SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait` cycles.
- Back-to-back requests: at least one IDLE cycle (`busy_o`=0) between transactions.
- Software observes `busy_o` with one extra cycle of input-buffer latency. The first poll after REQ toggle must come no earlier than 2 cycles after the store retires.
- `lcd_on_o` lags `lcd_word_i[9]` by one cycle.

## Test plan
Bench parameters: SETUP=2, EN_HIGH=3, HOLD=1, CMD_WAIT=5, CLR_WAIT=20, PWR_WAIT=10.

1. Reset pulse, word=0 → all outputs 0 and `busy_o`=1 during reset. `busy_o` stays 1 for 10 cycles after release, then 0. `lcd_en_o` never rises.
2. After power-up, word=0x0000_0541 (REQ=1, RS=1, DATA 'A') → `lcd_rs_o`=1 and `lcd_data_o`=0x41 from cycle 1. EN high on cycles 3–5. `busy_o` high for 11 cycles.
3. Word=0x0000_0001 with REQ toggled (clear) → RS=0, DATA=0x01, EN on cycles 3–5. `busy_o` high for 26 cycles.
4. During the step-2 transaction, change DATA to 0x42 without toggling REQ → EN pulse still carries 0x41. Then toggle REQ mid-transaction → second transaction starts after exactly one `busy_o`=0 cycle, carrying the DATA present at acceptance.
5. Toggle REQ twice while busy → after IDLE, no EN pulse and `busy_o` stays 0 for 50 cycles.
6. Assert `rst_i` during PULSE → `lcd_en_o`=0 in the same cycle and `busy_o`=1. After release: 10-cycle power-up, then a new transaction because REQ=1 differs from `req_seen`=0.

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-only controller: turns REQ-toggle command words into timed
// RS/DATA/EN write cycles, with a hardware power-up delay and busy flag.
module lcd_hd44780_ctrl #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_HIGH_CYC  = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned PWR_WAIT_CYC = 2000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lcd_word_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        busy_o
);

  localparam int unsigned MAX_A = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_B = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_C = (CLR_WAIT_CYC > PWR_WAIT_CYC) ? CLR_WAIT_CYC : PWR_WAIT_CYC;
  localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_ALL = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CW = $clog2(MAX_ALL) + 1;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_seen_q, req_seen_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          on_q, on_d;
  logic [7:0]    dout_q, dout_d;
  logic          rsout_q, rsout_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          long_wait;
  logic          drive;
  logic          unused_word;

  assign unused_word = ^lcd_word_i[31:11];
  assign long_wait   = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_seen_d = req_seen_q;
    data_d     = data_q;
    rs_d       = rs_q;
    on_d       = (state_q == ST_PWRUP) ? 1'b0 : lcd_word_i[9];
    unique case (state_q)
      ST_PWRUP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_IDLE: begin
        if (lcd_word_i[10] != req_seen_q) begin
          req_seen_d = lcd_word_i[10];
          data_d     = lcd_word_i[7:0];
          rs_d       = lcd_word_i[8];
          state_d    = ST_SETUP;
          cnt_d      = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(EN_HIGH_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = CW'(PWR_WAIT_CYC - 1);
      end
    endcase

    // Output flops are loaded from next-state so pins line up with the state they belong to.
    drive   = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    dout_d  = drive ? data_d : dout_q;
    rsout_d = drive ? rs_d : rsout_q;
    en_d    = (state_d == ST_PULSE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_PWRUP;
      cnt_q      <= CW'(PWR_WAIT_CYC - 1);
      req_seen_q <= 1'b0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      on_q       <= 1'b0;
      dout_q     <= '0;
      rsout_q    <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_seen_q <= req_seen_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      on_q       <= on_d;
      dout_q     <= dout_d;
      rsout_q    <= rsout_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
    end
  end

  assign lcd_data_o = dout_q;
  assign lcd_rs_o   = rsout_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model (power-up countdown, cycle index in write).
module tb_lcd_hd44780_ctrl;

  localparam int unsigned S   = 2;
  localparam int unsigned E   = 3;
  localparam int unsigned H   = 1;
  localparam int unsigned CMD = 5;
  localparam int unsigned CLR = 20;
  localparam int unsigned PWR = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] word = '0;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o;

  int checks = 0;
  int failures = 0;

  // Model: pw = power-up cycles left, k = cycle index within a write (0 = none), tot = write length.
  int          pw, k, tot;
  logic        m_seen, m_rs, m_rsout, m_on;
  logic [7:0]  m_data, m_dout;

  lcd_hd44780_ctrl #(
    .SETUP_CYC   (S),
    .EN_HIGH_CYC (E),
    .HOLD_CYC    (H),
    .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR),
    .PWR_WAIT_CYC(PWR)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .lcd_word_i(word),
    .lcd_data_o(lcd_data_o),
    .lcd_rs_o  (lcd_rs_o),
    .lcd_rw_o  (lcd_rw_o),
    .lcd_en_o  (lcd_en_o),
    .lcd_on_o  (lcd_on_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pw = PWR; k = 0; tot = 0;
    m_seen = 1'b0; m_dout = '0; m_rsout = 1'b0; m_on = 1'b0;
  endtask

  task automatic model_step();
    logic on_n;
    on_n = (pw > 0) ? 1'b0 : word[9];
    if (pw > 0) begin
      pw--;
    end else if (k > 0) begin
      k++;
      if (k > tot) k = 0;
    end else if (word[10] != m_seen) begin
      m_seen = word[10];
      m_data = word[7:0];
      m_rs   = word[8];
      tot    = S + E + H + ((!m_rs && m_data >= 8'd1 && m_data <= 8'd3) ? CLR : CMD);
      k      = 1;
      m_dout = m_data;
      m_rsout = m_rs;
    end
    m_on = on_n;
  endtask

  task automatic check_outputs();
    check_eq("data", lcd_data_o, m_dout);
    check_eq("rs",   lcd_rs_o,   m_rsout);
    check_eq("rw",   lcd_rw_o,   1'b0);
    check_eq("en",   lcd_en_o,   (k > S && k <= S + E));
    check_eq("on",   lcd_on_o,   m_on);
    check_eq("busy", busy_o,     (pw > 0 || k > 0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  // Drains any busy period, then counts idle cycles and the following busy period.
  task automatic measure(output int dlen, output int gap, output int blen, output int ecnt,
                         output logic [7:0] edata, output logic ers);
    dlen = 0; gap = 0; blen = 0; ecnt = 0; edata = '0; ers = 1'b0;
    while (busy_o && dlen < 200) begin dlen++; tick(); end
    while (!busy_o && gap < 200) begin gap++; tick(); end
    while (busy_o && blen < 200) begin
      blen++;
      if (lcd_en_o) begin ecnt++; edata = lcd_data_o; ers = lcd_rs_o; end
      tick();
    end
  endtask

  initial begin
    int dlen, gap, blen, ecnt, n, en_seen, guard;
    logic [7:0] edata;
    logic ers;

    model_reset();
    #2;
    // Step 1: power-up
    do_reset(2);
    n = 0; en_seen = 0;
    while (busy_o && n < 100) begin n++; if (lcd_en_o) en_seen++; tick(); end
    check_eq("pwrup_len", n, PWR);
    check_eq("pwrup_no_en", en_seen, 0);
    repeat (3) tick();

    // Step 2: data write 'A'
    word = 32'h0000_0541;
    measure(dlen, gap, blen, ecnt, edata, ers);
    check_eq("s2_busy_len", blen, 11);
    check_eq("s2_en_cnt", ecnt, 3);
    check_eq("s2_en_data", edata, 8'h41);
    check_eq("s2_en_rs", ers, 1'b1);

    // Step 3: clear display uses the long wait
    word = 32'h0000_0001;
    measure(dlen, gap, blen, ecnt, edata, ers);
    check_eq("s3_busy_len", blen, 26);
    check_eq("s3_en_cnt", ecnt, 3);
    check_eq("s3_en_data", edata, 8'h01);
    check_eq("s3_en_rs", ers, 1'b0);

    // Step 4: data change without toggle is ignored; toggle mid-write queues one write
    word = 32'h0000_0541;
    tick();
    word[7:0] = 8'h42;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (lcd_en_o && lcd_data_o == 8'h41) n++;
      tick();
    end
    check_eq("s4_en_old_data", n, 3);
    word[10] = ~word[10];
    measure(dlen, gap, blen, ecnt, edata, ers);
    check_eq("s4_gap", gap, 1);
    check_eq("s4_busy_len", blen, 11);
    check_eq("s4_en_data", edata, 8'h42);

    // Step 5: two toggles while busy cancel
    word[10] = ~word[10];
    repeat (3) tick();
    word[10] = ~word[10];
    repeat (2) tick();
    word[10] = ~word[10];
    guard = 0;
    while (busy_o && guard < 100) begin guard++; tick(); end
    n = 0; en_seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy_o) n++;
      if (lcd_en_o) en_seen++;
      tick();
    end
    check_eq("s5_no_busy", n, 0);
    check_eq("s5_no_en", en_seen, 0);

    // Step 6: reset during the EN pulse with REQ left at 1
    if (word[10]) begin
      word[10] = 1'b0;
      measure(dlen, gap, blen, ecnt, edata, ers);
    end
    word = 32'h0000_0548;
    guard = 0;
    while (!lcd_en_o && guard < 50) begin guard++; tick(); end
    check_eq("s6_en_reached", lcd_en_o, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("s6_en_drop", lcd_en_o, 1'b0);
    check_eq("s6_busy", busy_o, 1'b1);
    repeat (2) tick();
    rst = 1'b0;
    measure(dlen, gap, blen, ecnt, edata, ers);
    check_eq("s6_pwrup_len", dlen, PWR);
    check_eq("s6_gap", gap, 1);
    check_eq("s6_busy_len", blen, 11);
    check_eq("s6_en_data", edata, 8'h48);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 3));
      end else begin
        if (r < 40) begin
          word[31:11] = 21'($urandom);
          word[7:0]   = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
          word[8]     = 1'($urandom);
          word[9]     = 1'($urandom);
        end
        if ((pw == 0 && k == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3))
          word[10] = ~word[10];
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
